// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the fifo_v2 measurement FIFO family.
// Width helpers keep pointer/occupancy sizing consistent between the top and the RAM.
package fifo_pkg;

    localparam int DEFAULT_DEPTH  = 1024;
    localparam int DEFAULT_PTR_W  = $clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_SIZE_W = DEFAULT_PTR_W + 1;

    localparam int OVW_REJECT      = 0;
    localparam int OVW_DROP_OLDEST = 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int size_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Saturating increment for counters up to 64 bits wide.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for fifo_v2: one synchronous write port, one
// asynchronous read port, no reset, so it maps onto distributed RAM or flops.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int ADDR_W    = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_v2.sv
// Single-clock show-ahead FIFO with backpressure or overwrite-oldest mode,
// threshold flags, high-watermark tracking and saturating error counters.
module fifo_v2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 1024,
    parameter int AF_THRESH      = FIFO_DEPTH - 4,
    parameter int AE_THRESH      = 4,
    parameter int OVERWRITE_MODE = OVW_REJECT,
    parameter int ERR_CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_data_vld,
    output logic                         in_data_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_data_vld,
    output logic                         out_data_rdy,
    output logic [$clog2(FIFO_DEPTH)-1:0] out_data_ptr,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_size,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]  high_watermark,
    input  logic                         flush_fifo,
    output logic                         event_overflow,
    output logic                         event_underrun,
    output logic [ERR_CNT_WIDTH-1:0]     overflow_cnt,
    output logic [ERR_CNT_WIDTH-1:0]     underrun_cnt
);

    localparam int PTR_W  = ptr_w(FIFO_DEPTH);
    localparam int SIZE_W = size_w(FIFO_DEPTH);
    localparam logic [SIZE_W-1:0] DEPTH_SZ = SIZE_W'(FIFO_DEPTH);
    localparam logic [SIZE_W-1:0] AF_SZ    = SIZE_W'(AF_THRESH);
    localparam logic [SIZE_W-1:0] AE_SZ    = SIZE_W'(AE_THRESH);
    localparam logic OVW = (OVERWRITE_MODE == OVW_DROP_OLDEST);

    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("fifo_v2: FIFO_DEPTH must be a power of two and at least 4");
    end
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= FIFO_DEPTH))) begin : g_chk_thresh
        $error("fifo_v2: thresholds must satisfy AE_THRESH < AF_THRESH <= FIFO_DEPTH");
    end
    if ((OVERWRITE_MODE != OVW_REJECT) && (OVERWRITE_MODE != OVW_DROP_OLDEST)) begin : g_chk_mode
        $error("fifo_v2: OVERWRITE_MODE must be 0 or 1");
    end
    if ((ERR_CNT_WIDTH < 1) || (ERR_CNT_WIDTH > 64)) begin : g_chk_cnt
        $error("fifo_v2: ERR_CNT_WIDTH must be between 1 and 64");
    end

    logic [PTR_W-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [SIZE_W-1:0]        size_reg, size_next;
    logic [SIZE_W-1:0]        hw_reg, hw_next;
    logic                     af_reg, ae_reg;
    logic                     ovf_evt_reg, und_evt_reg;
    logic                     ovf_cond, und_cond;
    logic [ERR_CNT_WIDTH-1:0] ovf_cnt_reg, ovf_cnt_next;
    logic [ERR_CNT_WIDTH-1:0] und_cnt_reg, und_cnt_next;
    logic                     full, empty, push, pop, drop_oldest;
    logic [DATA_WIDTH-1:0]    ram_rd_data;

    assign full        = (size_reg == DEPTH_SZ);
    assign empty       = (size_reg == '0);
    assign in_data_rdy = OVW | ~full;
    assign push        = in_data_vld & in_data_rdy;
    assign pop         = out_data_vld & ~empty;
    // Writing into a full FIFO (overwrite mode only) evicts the head entry.
    assign drop_oldest = push & full;
    assign ovf_cond    = in_data_vld & full & (~OVW | ~pop);
    assign und_cond    = out_data_vld & empty;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        size_next    = size_reg;
        hw_next      = hw_reg;
        ovf_cnt_next = ovf_cnt_reg;
        und_cnt_next = und_cnt_reg;
        if (flush_fifo) begin
            wr_ptr_next  = '0;
            rd_ptr_next  = '0;
            size_next    = '0;
            hw_next      = '0;
            ovf_cnt_next = '0;
            und_cnt_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop | drop_oldest) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push & ~pop & ~full) begin
                size_next = size_reg + 1'b1;
            end else if (pop & ~push) begin
                size_next = size_reg - 1'b1;
            end
            hw_next = (size_next > hw_reg) ? size_next : hw_reg;
            if (ovf_cond) begin
                ovf_cnt_next = ERR_CNT_WIDTH'(sat_inc(64'(ovf_cnt_reg), ERR_CNT_WIDTH));
            end
            if (und_cond) begin
                und_cnt_next = ERR_CNT_WIDTH'(sat_inc(64'(und_cnt_reg), ERR_CNT_WIDTH));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            size_reg    <= '0;
            hw_reg      <= '0;
            af_reg      <= 1'b0;
            ae_reg      <= 1'b1;
            ovf_evt_reg <= 1'b0;
            und_evt_reg <= 1'b0;
            ovf_cnt_reg <= '0;
            und_cnt_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            size_reg    <= size_next;
            hw_reg      <= hw_next;
            af_reg      <= (size_next >= AF_SZ);
            ae_reg      <= (size_next <= AE_SZ);
            ovf_evt_reg <= ovf_cond & ~flush_fifo;
            und_evt_reg <= und_cond & ~flush_fifo;
            ovf_cnt_reg <= ovf_cnt_next;
            und_cnt_reg <= und_cnt_next;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .we      (push & ~flush_fifo),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_rd_data)
    );

    assign out_data       = empty ? '0 : ram_rd_data;
    assign out_data_rdy   = ~empty;
    assign out_data_ptr   = rd_ptr_reg;
    assign fifo_size      = size_reg;
    assign almost_full    = af_reg;
    assign almost_empty   = ae_reg;
    assign high_watermark = hw_reg;
    assign event_overflow = ovf_evt_reg;
    assign event_underrun = und_evt_reg;
    assign overflow_cnt   = ovf_cnt_reg;
    assign underrun_cnt   = und_cnt_reg;

endmodule

// File: tb/tb_fifo_v2.sv
// Self-checking bench for fifo_v2: directed scenarios plus randomized traffic
// compared against a queue-based model, for both reject and overwrite modes.
module tb_fifo_v2;

    localparam int DW = 32, DEPTH = 8, AF = 6, AE = 1, CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // Reject-mode instance (a_*) and overwrite-mode instance (b_*)
    logic [DW-1:0] a_in_data, a_out_data, b_in_data, b_out_data;
    logic a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_af, a_ae, a_flush, a_ovf, a_und;
    logic b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_af, b_ae, b_flush, b_ovf, b_und;
    logic [2:0] a_ptr, b_ptr;
    logic [3:0] a_size, b_size, a_hw, b_hw;
    logic [CW-1:0] a_ovf_cnt, a_und_cnt, b_ovf_cnt, b_und_cnt;

    fifo_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
              .OVERWRITE_MODE(0), .ERR_CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rstn(rstn), .in_data(a_in_data), .in_data_vld(a_in_vld),
        .in_data_rdy(a_in_rdy), .out_data(a_out_data), .out_data_vld(a_out_vld),
        .out_data_rdy(a_out_rdy), .out_data_ptr(a_ptr), .fifo_size(a_size),
        .almost_full(a_af), .almost_empty(a_ae), .high_watermark(a_hw),
        .flush_fifo(a_flush), .event_overflow(a_ovf), .event_underrun(a_und),
        .overflow_cnt(a_ovf_cnt), .underrun_cnt(a_und_cnt));

    fifo_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE),
              .OVERWRITE_MODE(1), .ERR_CNT_WIDTH(CW)) u_ovw (
        .clk(clk), .rstn(rstn), .in_data(b_in_data), .in_data_vld(b_in_vld),
        .in_data_rdy(b_in_rdy), .out_data(b_out_data), .out_data_vld(b_out_vld),
        .out_data_rdy(b_out_rdy), .out_data_ptr(b_ptr), .fifo_size(b_size),
        .almost_full(b_af), .almost_empty(b_ae), .high_watermark(b_hw),
        .flush_fifo(b_flush), .event_overflow(b_ovf), .event_underrun(b_und),
        .overflow_cnt(b_ovf_cnt), .underrun_cnt(b_und_cnt));

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: contents as a queue, pointer as a count of head removals
    logic [DW-1:0] mq[$];
    int m_ptr, m_ovf, m_und, m_ovf_cnt, m_und_cnt, m_hw;

    task automatic model_clear();
        mq.delete();
        m_ptr = 0; m_ovf = 0; m_und = 0; m_ovf_cnt = 0; m_und_cnt = 0; m_hw = 0;
    endtask

    task automatic model_step(input int mode, input logic vld, input logic [DW-1:0] d,
                              input logic ovld, input logic fl);
        bit full, empty, push, pop;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (fl) begin
            model_clear();
            return;
        end
        push  = vld && (mode == 1 || !full);
        pop   = ovld && !empty;
        m_ovf = (vld && full && (mode == 0 || !pop)) ? 1 : 0;
        m_und = (ovld && empty) ? 1 : 0;
        if (pop) begin
            void'(mq.pop_front());
            m_ptr++;
        end
        if (push) begin
            if (mq.size() == DEPTH) begin
                void'(mq.pop_front());
                m_ptr++;
            end
            mq.push_back(d);
        end
        if (m_ovf == 1 && m_ovf_cnt < 65535) m_ovf_cnt++;
        if (m_und == 1 && m_und_cnt < 65535) m_und_cnt++;
        if (mq.size() > m_hw) m_hw = mq.size();
    endtask

    task automatic drive0(input logic vld, input logic [DW-1:0] d, input logic ovld, input logic fl);
        a_in_vld = vld; a_in_data = d; a_out_vld = ovld; a_flush = fl;
        @(posedge clk); #1;
        model_step(0, vld, d, ovld, fl);
    endtask

    task automatic drive1(input logic vld, input logic [DW-1:0] d, input logic ovld, input logic fl);
        b_in_vld = vld; b_in_data = d; b_out_vld = ovld; b_flush = fl;
        @(posedge clk); #1;
        model_step(1, vld, d, ovld, fl);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        a_in_vld = 0; a_in_data = '0; a_out_vld = 0; a_flush = 0;
        b_in_vld = 0; b_in_data = '0; b_out_vld = 0; b_flush = 0;
        #23;
        n_checks++; if (a_size !== 4'd0) begin n_fail++; $display("FAIL reset_size got=%0d exp=0", a_size); end
        n_checks++; if (a_out_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_out_rdy got=%0b exp=0", a_out_rdy); end
        n_checks++; if (a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got=%0b exp=1", a_in_rdy); end
        n_checks++; if (a_out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got=%0h exp=0", a_out_data); end
        n_checks++; if ({a_ae, a_af} !== 2'b10) begin n_fail++; $display("FAIL reset_flags got=%b exp=10", {a_ae, a_af}); end
        rstn = 1'b1;
        model_clear();
        $display("test_reset done");
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            drive0(1, 32'h10 + i, 0, 0);
            n_checks++; if (a_size !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_size got=%0d exp=%0d", a_size, i + 1); end
            n_checks++; if (a_af !== ((i + 1) >= 6)) begin n_fail++; $display("FAIL fill_af size=%0d got=%0b", i + 1, a_af); end
            n_checks++; if (a_in_rdy !== ((i + 1) < 8)) begin n_fail++; $display("FAIL fill_in_rdy size=%0d got=%0b", i + 1, a_in_rdy); end
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (a_out_data !== 32'h10 + i) begin n_fail++; $display("FAIL drain_data got=%0h exp=%0h", a_out_data, 32'h10 + i); end
            drive0(0, '0, 1, 0);
        end
        n_checks++; if (a_out_data !== 32'd0 || a_out_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_empty data=%0h rdy=%0b exp=0/0", a_out_data, a_out_rdy); end
        $display("test_fill_drain done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) drive0(1, 32'h20 + i, 0, 0);
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before got=%0b exp=0", a_ovf); end
        for (int k = 0; k < 3; k++) begin
            drive0(1, 32'hDEAD0000 + k, 0, 0);
            n_checks++; if (a_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse k=%0d got=%0b exp=1", k, a_ovf); end
        end
        drive0(0, '0, 0, 0);
        n_checks++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_after got=%0b exp=0", a_ovf); end
        n_checks++; if (a_ovf_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_cnt got=%0d exp=3", a_ovf_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (a_out_data !== 32'h20 + i) begin n_fail++; $display("FAIL ovf_contents got=%0h exp=%0h", a_out_data, 32'h20 + i); end
            drive0(0, '0, 1, 0);
        end
        $display("test_overflow done");
    endtask

    task automatic test_underrun_wrap();
        bit wrapped = 0;
        logic [2:0] prev;
        drive0(0, '0, 1, 0);
        n_checks++; if (a_und !== 1'b1) begin n_fail++; $display("FAIL und_pulse got=%0b exp=1", a_und); end
        n_checks++; if (a_und_cnt !== 16'd1) begin n_fail++; $display("FAIL und_cnt got=%0d exp=1", a_und_cnt); end
        drive0(0, '0, 0, 0);
        n_checks++; if (a_und !== 1'b0) begin n_fail++; $display("FAIL und_after got=%0b exp=0", a_und); end
        for (int i = 0; i < 3; i++) drive0(1, 32'h30 + i, 0, 0);
        for (int i = 0; i < 20; i++) begin
            prev = a_ptr;
            drive0(1, 32'h40 + i, 1, 0);
            if (prev == 3'd7 && a_ptr == 3'd0) wrapped = 1;
            n_checks++; if (a_size !== 4'd3) begin n_fail++; $display("FAIL wrap_size got=%0d exp=3", a_size); end
            n_checks++; if (a_out_data !== mq[0]) begin n_fail++; $display("FAIL wrap_data got=%0h exp=%0h", a_out_data, mq[0]); end
            n_checks++; if (a_ptr !== 3'(m_ptr % DEPTH)) begin n_fail++; $display("FAIL wrap_ptr got=%0d exp=%0d", a_ptr, m_ptr % DEPTH); end
        end
        n_checks++; if (wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_seen got=%0b exp=1", wrapped); end
        $display("test_underrun_wrap done");
    endtask

    task automatic test_overwrite();
        drive1(0, '0, 0, 1);
        for (int i = 0; i < 10; i++) drive1(1, i, 0, 0);
        n_checks++; if (b_size !== 4'd8) begin n_fail++; $display("FAIL ovw_size got=%0d exp=8", b_size); end
        n_checks++; if (b_out_data !== 32'h2) begin n_fail++; $display("FAIL ovw_head got=%0h exp=2", b_out_data); end
        n_checks++; if (b_ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL ovw_ovf_cnt got=%0d exp=2", b_ovf_cnt); end
        n_checks++; if (b_in_rdy !== 1'b1) begin n_fail++; $display("FAIL ovw_in_rdy got=%0b exp=1", b_in_rdy); end
        for (int i = 2; i < 10; i++) begin
            n_checks++; if (b_out_data !== 32'(i)) begin n_fail++; $display("FAIL ovw_order got=%0h exp=%0h", b_out_data, i); end
            drive1(0, '0, 1, 0);
        end
        $display("test_overwrite done");
    endtask

    task automatic test_flush_watermark();
        drive0(0, '0, 0, 1);
        drive0(0, '0, 1, 0);
        for (int i = 0; i < 5; i++) drive0(1, 32'h50 + i, 0, 0);
        n_checks++; if (a_hw !== 4'd5) begin n_fail++; $display("FAIL hw_before got=%0d exp=5", a_hw); end
        drive0(0, '0, 1, 0);
        drive0(0, '0, 1, 0);
        n_checks++; if (a_hw !== 4'd5 || a_size !== 4'd3) begin n_fail++; $display("FAIL hw_after_pop hw=%0d size=%0d exp=5/3", a_hw, a_size); end
        n_checks++; if (a_und_cnt !== 16'd1) begin n_fail++; $display("FAIL und_cnt_pre_flush got=%0d exp=1", a_und_cnt); end
        drive0(1, 32'hBAD, 1, 1);
        n_checks++; if (a_size !== 4'd0 || a_hw !== 4'd0) begin n_fail++; $display("FAIL flush_state size=%0d hw=%0d exp=0/0", a_size, a_hw); end
        n_checks++; if (a_und_cnt !== 16'd0 || a_ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt und=%0d ovf=%0d exp=0/0", a_und_cnt, a_ovf_cnt); end
        n_checks++; if ({a_ae, a_af} !== 2'b10) begin n_fail++; $display("FAIL flush_flags got=%b exp=10", {a_ae, a_af}); end
        drive0(0, '0, 0, 0);
        n_checks++; if (a_size !== 4'd0 || a_out_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_push_lost size=%0d rdy=%0b exp=0/0", a_size, a_out_rdy); end
        $display("test_flush_watermark done");
    endtask

    task automatic test_random(input int mode);
        logic [DW-1:0] o_data;
        logic [3:0] o_size, o_hw;
        logic [2:0] o_ptr;
        logic o_rdy, o_in_rdy, o_af, o_ae, o_ovf, o_und;
        logic [CW-1:0] o_ovf_cnt, o_und_cnt;
        logic vld, ovld, fl;
        logic [DW-1:0] d;
        if (mode == 0) drive0(0, '0, 0, 1); else drive1(0, '0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            vld  = ($urandom_range(0, 99) < 60);
            ovld = ($urandom_range(0, 99) < 45);
            fl   = ($urandom_range(0, 63) == 0);
            d    = $urandom;
            if (mode == 0) begin
                drive0(vld, d, ovld, fl);
                o_data = a_out_data; o_size = a_size; o_hw = a_hw; o_ptr = a_ptr; o_rdy = a_out_rdy;
                o_in_rdy = a_in_rdy; o_af = a_af; o_ae = a_ae; o_ovf = a_ovf; o_und = a_und;
                o_ovf_cnt = a_ovf_cnt; o_und_cnt = a_und_cnt;
            end else begin
                drive1(vld, d, ovld, fl);
                o_data = b_out_data; o_size = b_size; o_hw = b_hw; o_ptr = b_ptr; o_rdy = b_out_rdy;
                o_in_rdy = b_in_rdy; o_af = b_af; o_ae = b_ae; o_ovf = b_ovf; o_und = b_und;
                o_ovf_cnt = b_ovf_cnt; o_und_cnt = b_und_cnt;
            end
            n_checks++; if (o_size !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd%0d_size cyc=%0d got=%0d exp=%0d", mode, i, o_size, mq.size()); end
            n_checks++; if (o_data !== ((mq.size() > 0) ? mq[0] : 32'd0)) begin n_fail++; $display("FAIL rnd%0d_data cyc=%0d got=%0h", mode, i, o_data); end
            n_checks++; if (o_rdy !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd%0d_out_rdy cyc=%0d got=%0b", mode, i, o_rdy); end
            n_checks++; if (o_in_rdy !== (mode == 1 || mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd%0d_in_rdy cyc=%0d got=%0b", mode, i, o_in_rdy); end
            n_checks++; if (o_af !== (mq.size() >= AF) || o_ae !== (mq.size() <= AE)) begin n_fail++; $display("FAIL rnd%0d_flags cyc=%0d af=%0b ae=%0b size=%0d", mode, i, o_af, o_ae, mq.size()); end
            n_checks++; if (o_hw !== 4'(m_hw)) begin n_fail++; $display("FAIL rnd%0d_hw cyc=%0d got=%0d exp=%0d", mode, i, o_hw, m_hw); end
            n_checks++; if (o_ptr !== 3'(m_ptr % DEPTH)) begin n_fail++; $display("FAIL rnd%0d_ptr cyc=%0d got=%0d exp=%0d", mode, i, o_ptr, m_ptr % DEPTH); end
            n_checks++; if (o_ovf !== 1'(m_ovf) || o_und !== 1'(m_und)) begin n_fail++; $display("FAIL rnd%0d_events cyc=%0d ovf=%0b und=%0b exp=%0d/%0d", mode, i, o_ovf, o_und, m_ovf, m_und); end
            n_checks++; if (o_ovf_cnt !== 16'(m_ovf_cnt) || o_und_cnt !== 16'(m_und_cnt)) begin n_fail++; $display("FAIL rnd%0d_cnts cyc=%0d ovf=%0d und=%0d exp=%0d/%0d", mode, i, o_ovf_cnt, o_und_cnt, m_ovf_cnt, m_und_cnt); end
        end
        $display("test_random mode=%0d done", mode);
    endtask

    task automatic test_async_reset();
        drive0(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) drive0(1, 32'h60 + i, 0, 0);
        a_in_vld = 1; a_in_data = 32'h63;
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        n_checks++; if (a_size !== 4'd0 || a_out_rdy !== 1'b0) begin n_fail++; $display("FAIL arst_size size=%0d rdy=%0b exp=0/0", a_size, a_out_rdy); end
        n_checks++; if (a_out_data !== 32'd0 || a_in_rdy !== 1'b1) begin n_fail++; $display("FAIL arst_data data=%0h in_rdy=%0b exp=0/1", a_out_data, a_in_rdy); end
        n_checks++; if (a_hw !== 4'd0 || a_ae !== 1'b1) begin n_fail++; $display("FAIL arst_hw hw=%0d ae=%0b exp=0/1", a_hw, a_ae); end
        a_in_vld = 0; a_out_vld = 0; a_flush = 0;
        @(posedge clk); #3;
        rstn = 1'b1;
        model_clear();
        drive0(1, 32'hAB, 0, 0);
        n_checks++; if (a_out_data !== 32'hAB || a_size !== 4'd1) begin n_fail++; $display("FAIL arst_first_push data=%0h size=%0d exp=ab/1", a_out_data, a_size); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underrun_wrap();
        test_overwrite();
        test_flush_watermark();
        test_random(0);
        test_random(1);
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
